// File: rtl/exu_bjp_rslv_if.sv
// Request/response bundle between the BJP issue path, the resolution unit and commit/writeback.
interface exu_bjp_rslv_if #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32
);
  logic               bjp_i_valid;
  logic               bjp_i_ready;
  logic [XLEN-1:0]    bjp_i_rs1;
  logic [XLEN-1:0]    bjp_i_rs2;
  logic [XLEN-1:0]    bjp_i_imm;
  logic [PC_SIZE-1:0] bjp_i_pc;
  logic [5:0]         bjp_i_cmp;
  logic               bjp_i_bxx;
  logic               bjp_i_jump;
  logic               bjp_i_jalr;
  logic               bjp_i_rv32;
  logic               bjp_i_bprdt;
  logic               bjp_i_mret;
  logic               bjp_i_dret;
  logic               bjp_i_fencei;
  logic               bjp_i_flush;

  logic               bjp_o_valid;
  logic               bjp_o_ready;
  logic [XLEN-1:0]    bjp_o_wbck_dat;
  logic               bjp_o_wbck_en;
  logic               bjp_o_cmt_bjp;
  logic               bjp_o_cmt_mret;
  logic               bjp_o_cmt_dret;
  logic               bjp_o_cmt_fencei;
  logic               bjp_o_cmt_prdt;
  logic               bjp_o_cmt_rslv;
  logic               bjp_o_cmt_mispred;
  logic [PC_SIZE-1:0] bjp_o_flush_pc;

  // The resolution unit itself.
  modport slave (
    input  bjp_i_valid, bjp_i_rs1, bjp_i_rs2, bjp_i_imm, bjp_i_pc, bjp_i_cmp,
           bjp_i_bxx, bjp_i_jump, bjp_i_jalr, bjp_i_rv32, bjp_i_bprdt,
           bjp_i_mret, bjp_i_dret, bjp_i_fencei, bjp_i_flush, bjp_o_ready,
    output bjp_i_ready, bjp_o_valid, bjp_o_wbck_dat, bjp_o_wbck_en,
           bjp_o_cmt_bjp, bjp_o_cmt_mret, bjp_o_cmt_dret, bjp_o_cmt_fencei,
           bjp_o_cmt_prdt, bjp_o_cmt_rslv, bjp_o_cmt_mispred, bjp_o_flush_pc
  );

  // Issue side plus commit/writeback side, as seen from outside the unit.
  modport master (
    output bjp_i_valid, bjp_i_rs1, bjp_i_rs2, bjp_i_imm, bjp_i_pc, bjp_i_cmp,
           bjp_i_bxx, bjp_i_jump, bjp_i_jalr, bjp_i_rv32, bjp_i_bprdt,
           bjp_i_mret, bjp_i_dret, bjp_i_fencei, bjp_i_flush, bjp_o_ready,
    input  bjp_i_ready, bjp_o_valid, bjp_o_wbck_dat, bjp_o_wbck_en,
           bjp_o_cmt_bjp, bjp_o_cmt_mret, bjp_o_cmt_dret, bjp_o_cmt_fencei,
           bjp_o_cmt_prdt, bjp_o_cmt_rslv, bjp_o_cmt_mispred, bjp_o_flush_pc
  );
endinterface

// File: rtl/exu_bjp_rslv.sv
// Branch/jump resolution with private comparator/adders and an OBUF_DEPTH-entry output buffer.
// Optional taken/mispredict statistics counters are enabled by defining E203_BJP_STAT_EN.
module exu_bjp_rslv #(
  parameter int XLEN       = 32,
  parameter int PC_SIZE    = 32,
  parameter int OBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef E203_BJP_STAT_EN
  output logic [31:0] bjp_stat_taken_cnt,
  output logic [31:0] bjp_stat_mispred_cnt,
`endif
  exu_bjp_rslv_if.slave bjp_if
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0]    wbck_dat;
    logic               wbck_en;
    logic               bjp;
    logic               mret;
    logic               dret;
    logic               fencei;
    logic               prdt;
    logic               rslv;
    logic               mispred;
    logic [PC_SIZE-1:0] flush_pc;
  } ent_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef E203_BJP_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
`endif

  // Resolve stage: direction, target and link from the incoming request
  logic signed [XLEN-1:0] rs1_s, rs2_s, imm_s;
  logic                   cmp_eq, cmp_lt, cmp_ltu, cmp_hit, rslv;
  logic [5:0]             cmp_vec;
  logic [PC_SIZE-1:0]     tgt_base, tgt_sum, tgt, link_pc;
  ent_t                   ent_d;

  assign rs1_s   = bjp_if.bjp_i_rs1;
  assign rs2_s   = bjp_if.bjp_i_rs2;
  assign imm_s   = bjp_if.bjp_i_imm;

  assign cmp_eq  = (bjp_if.bjp_i_rs1 == bjp_if.bjp_i_rs2);
  assign cmp_lt  = (rs1_s < rs2_s);
  assign cmp_ltu = (bjp_if.bjp_i_rs1 < bjp_if.bjp_i_rs2);
  assign cmp_vec = {~cmp_ltu, cmp_ltu, ~cmp_lt, cmp_lt, ~cmp_eq, cmp_eq};
  assign cmp_hit = |(bjp_if.bjp_i_cmp & cmp_vec);
  assign rslv    = bjp_if.bjp_i_jump | (bjp_if.bjp_i_bxx & cmp_hit);

  assign tgt_base = bjp_if.bjp_i_jalr ? PC_SIZE'(bjp_if.bjp_i_rs1) : bjp_if.bjp_i_pc;
  assign tgt_sum  = tgt_base + PC_SIZE'(imm_s);
  assign tgt      = bjp_if.bjp_i_jalr ? {tgt_sum[PC_SIZE-1:1], 1'b0} : tgt_sum;
  assign link_pc  = bjp_if.bjp_i_pc + (bjp_if.bjp_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));

  always_comb begin
    ent_d          = '0;
    ent_d.wbck_dat = XLEN'(link_pc);
    ent_d.wbck_en  = bjp_if.bjp_i_jump;
    ent_d.bjp      = bjp_if.bjp_i_bxx | bjp_if.bjp_i_jump;
    ent_d.mret     = bjp_if.bjp_i_mret;
    ent_d.dret     = bjp_if.bjp_i_dret;
    ent_d.fencei   = bjp_if.bjp_i_fencei;
    ent_d.prdt     = bjp_if.bjp_i_bprdt;
    ent_d.rslv     = rslv;
    ent_d.mispred  = (bjp_if.bjp_i_bxx | bjp_if.bjp_i_jump) & (bjp_if.bjp_i_bprdt != rslv);
    ent_d.flush_pc = rslv ? tgt : link_pc;
  end

  // Buffer stage: circular entry store, pointers and occupancy
  ent_t             ent_q [OBUF_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic             i_rdy, o_vld, push, pop;
  ent_t             head;

  assign i_rdy = (cnt_q < CNT_W'(OBUF_DEPTH));
  assign o_vld = (cnt_q != '0);
  assign push  = bjp_if.bjp_i_valid & i_rdy;
  assign pop   = o_vld & bjp_if.bjp_o_ready;

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bjp_if.bjp_i_flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      // A flushed cycle drops the offered request entirely.
      if (push && !bjp_if.bjp_i_flush) ent_q[wr_ptr_q] <= ent_d;
    end
  end

  // Output stage: everything comes from the head entry registers
  assign head = ent_q[rd_ptr_q];

  assign bjp_if.bjp_i_ready       = i_rdy;
  assign bjp_if.bjp_o_valid       = o_vld;
  assign bjp_if.bjp_o_wbck_dat    = head.wbck_dat;
  assign bjp_if.bjp_o_wbck_en     = head.wbck_en & o_vld;
  assign bjp_if.bjp_o_cmt_bjp     = head.bjp;
  assign bjp_if.bjp_o_cmt_mret    = head.mret;
  assign bjp_if.bjp_o_cmt_dret    = head.dret;
  assign bjp_if.bjp_o_cmt_fencei  = head.fencei;
  assign bjp_if.bjp_o_cmt_prdt    = head.prdt;
  assign bjp_if.bjp_o_cmt_rslv    = head.rslv;
  assign bjp_if.bjp_o_cmt_mispred = head.mispred & o_vld;
  assign bjp_if.bjp_o_flush_pc    = head.flush_pc;

`ifdef E203_BJP_STAT_EN
  logic [31:0] stat_taken_q, stat_mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q   <= '0;
      stat_mispred_q <= '0;
    end else if (pop) begin
      if (head.rslv)    stat_taken_q   <= sat_inc(stat_taken_q);
      if (head.mispred) stat_mispred_q <= sat_inc(stat_mispred_q);
    end
  end

  assign bjp_stat_taken_cnt   = stat_taken_q;
  assign bjp_stat_mispred_cnt = stat_mispred_q;
`endif

endmodule

// File: tb/tb_exu_bjp_rslv.sv
// Directed bench for exu_bjp_rslv: resolution results, buffering, flush and reset behaviour.
module tb_exu_bjp_rslv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exu_bjp_rslv_if #(.XLEN(32), .PC_SIZE(32)) bif ();

`ifdef E203_BJP_STAT_EN
  logic [31:0] stat_taken, stat_mispred;
`endif

  exu_bjp_rslv #(.XLEN(32), .PC_SIZE(32), .OBUF_DEPTH(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
`ifdef E203_BJP_STAT_EN
    .bjp_stat_taken_cnt   (stat_taken),
    .bjp_stat_mispred_cnt (stat_mispred),
`endif
    .bjp_if               (bif)
  );

  task automatic idle_req();
    bif.bjp_i_valid = 0; bif.bjp_i_rs1 = 0; bif.bjp_i_rs2 = 0; bif.bjp_i_imm = 0;
    bif.bjp_i_pc = 0; bif.bjp_i_cmp = 0; bif.bjp_i_bxx = 0; bif.bjp_i_jump = 0;
    bif.bjp_i_jalr = 0; bif.bjp_i_rv32 = 0; bif.bjp_i_bprdt = 0;
    bif.bjp_i_mret = 0; bif.bjp_i_dret = 0; bif.bjp_i_fencei = 0;
  endtask

  task automatic set_req(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [5:0] cmp, input logic bxx,
                         input logic jump, input logic jalr, input logic rv32, input logic bprdt);
    idle_req();
    bif.bjp_i_valid = 1; bif.bjp_i_rs1 = rs1; bif.bjp_i_rs2 = rs2; bif.bjp_i_imm = imm;
    bif.bjp_i_pc = pc; bif.bjp_i_cmp = cmp; bif.bjp_i_bxx = bxx; bif.bjp_i_jump = jump;
    bif.bjp_i_jalr = jalr; bif.bjp_i_rv32 = rv32; bif.bjp_i_bprdt = bprdt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_req();
    bif.bjp_o_ready = 0; bif.bjp_i_flush = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", bif.bjp_i_ready); end
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h0) begin n_fail++; $display("FAIL reset_wbck_dat: got %h want 0", bif.bjp_o_wbck_dat); end
    n_chk++; if (bif.bjp_o_flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc: got %h want 0", bif.bjp_o_flush_pc); end
    n_chk++; if ({bif.bjp_o_cmt_bjp, bif.bjp_o_cmt_mret, bif.bjp_o_cmt_dret, bif.bjp_o_cmt_fencei,
                  bif.bjp_o_cmt_prdt, bif.bjp_o_cmt_rslv, bif.bjp_o_cmt_mispred, bif.bjp_o_wbck_en} !== 8'h0) begin
      n_fail++; $display("FAIL reset_flags: got nonzero flags want 0");
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_beq();
    set_req(32'h10, 32'h10, 32'h20, 32'h100, 6'b000001, 1, 0, 0, 1, 0);
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %b want 1", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_o_cmt_rslv !== 1'b1) begin n_fail++; $display("FAIL beq_rslv: got %b want 1", bif.bjp_o_cmt_rslv); end
    n_chk++; if (bif.bjp_o_cmt_mispred !== 1'b1) begin n_fail++; $display("FAIL beq_mispred: got %b want 1", bif.bjp_o_cmt_mispred); end
    n_chk++; if (bif.bjp_o_flush_pc !== 32'h120) begin n_fail++; $display("FAIL beq_flush_pc: got %h want 120", bif.bjp_o_flush_pc); end
    n_chk++; if (bif.bjp_o_wbck_en !== 1'b0) begin n_fail++; $display("FAIL beq_wbck_en: got %b want 0", bif.bjp_o_wbck_en); end
    n_chk++; if (bif.bjp_o_cmt_bjp !== 1'b1) begin n_fail++; $display("FAIL beq_cmt_bjp: got %b want 1", bif.bjp_o_cmt_bjp); end
    bif.bjp_o_ready = 1;
    step();
    bif.bjp_o_ready = 0;
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL beq_popped: got %b want 0", bif.bjp_o_valid); end
  endtask

  task automatic test_jalr();
    set_req(32'h2001, 32'h0, 32'h4, 32'h80, 6'b000000, 0, 1, 1, 1, 1);
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_cmt_rslv !== 1'b1) begin n_fail++; $display("FAIL jalr_rslv: got %b want 1", bif.bjp_o_cmt_rslv); end
    n_chk++; if (bif.bjp_o_cmt_mispred !== 1'b0) begin n_fail++; $display("FAIL jalr_mispred: got %b want 0", bif.bjp_o_cmt_mispred); end
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h84) begin n_fail++; $display("FAIL jalr_wbck_dat: got %h want 84", bif.bjp_o_wbck_dat); end
    n_chk++; if (bif.bjp_o_wbck_en !== 1'b1) begin n_fail++; $display("FAIL jalr_wbck_en: got %b want 1", bif.bjp_o_wbck_en); end
    n_chk++; if (bif.bjp_o_flush_pc !== 32'h2004) begin n_fail++; $display("FAIL jalr_target: got %h want 2004", bif.bjp_o_flush_pc); end
    bif.bjp_o_ready = 1;
    step();
    bif.bjp_o_ready = 0;
  endtask

  task automatic test_cmp_signed();
    // BLT signed: -1 < 1, predicted taken
    set_req(32'hFFFF_FFFF, 32'h1, 32'h40, 32'h200, 6'b000100, 1, 0, 0, 0, 1);
    step();
    n_chk++; if (bif.bjp_o_cmt_rslv !== 1'b1) begin n_fail++; $display("FAIL blt_rslv: got %b want 1", bif.bjp_o_cmt_rslv); end
    n_chk++; if (bif.bjp_o_cmt_mispred !== 1'b0) begin n_fail++; $display("FAIL blt_mispred: got %b want 0", bif.bjp_o_cmt_mispred); end
    n_chk++; if (bif.bjp_o_flush_pc !== 32'h240) begin n_fail++; $display("FAIL blt_target: got %h want 240", bif.bjp_o_flush_pc); end
    // BLTU on the same operands pushed while BLT pops
    set_req(32'hFFFF_FFFF, 32'h1, 32'h40, 32'h200, 6'b010000, 1, 0, 0, 0, 1);
    bif.bjp_o_ready = 1;
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_valid: got %b want 1", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_o_cmt_rslv !== 1'b0) begin n_fail++; $display("FAIL bltu_rslv: got %b want 0", bif.bjp_o_cmt_rslv); end
    n_chk++; if (bif.bjp_o_cmt_mispred !== 1'b1) begin n_fail++; $display("FAIL bltu_mispred: got %b want 1", bif.bjp_o_cmt_mispred); end
    n_chk++; if (bif.bjp_o_flush_pc !== 32'h202) begin n_fail++; $display("FAIL bltu_link_pc: got %h want 202", bif.bjp_o_flush_pc); end
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h202) begin n_fail++; $display("FAIL bltu_wbck_dat: got %h want 202", bif.bjp_o_wbck_dat); end
    step();
    bif.bjp_o_ready = 0;
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL bltu_popped: got %b want 0", bif.bjp_o_valid); end
  endtask

  task automatic test_cmp_table();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [5:0]  c [3];
    logic        exp [3];
    a[0] = 32'h7;          b[0] = 32'h7;          c[0] = 6'b000010; exp[0] = 0; // BNE equal
    a[1] = 32'h5;          b[1] = 32'hFFFF_FFFD;  c[1] = 6'b001000; exp[1] = 1; // BGE 5 >= -3
    a[2] = 32'h1;          b[2] = 32'hFFFF_FFFF;  c[2] = 6'b100000; exp[2] = 0; // BGEU 1 >= max
    bif.bjp_o_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_req(a[i], b[i], 32'h10, 32'h400, c[i], 1, 0, 0, 1, 0);
      step();
      idle_req();
      n_chk++; if (bif.bjp_o_cmt_rslv !== exp[i]) begin n_fail++; $display("FAIL cmp_table_%0d: got %b want %b", i, bif.bjp_o_cmt_rslv, exp[i]); end
      step();
    end
    bif.bjp_o_ready = 0;
  endtask

  task automatic test_back_to_back();
    bif.bjp_o_ready = 0;
    set_req(32'h0, 32'h0, 32'h100, 32'h10, 6'b0, 0, 1, 0, 1, 1);
    step();
    n_chk++; if (bif.bjp_i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_1: got %b want 1", bif.bjp_i_ready); end
    set_req(32'h0, 32'h0, 32'h100, 32'h20, 6'b0, 0, 1, 0, 1, 1);
    step();
    n_chk++; if (bif.bjp_i_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_2: got %b want 0", bif.bjp_i_ready); end
    set_req(32'h0, 32'h0, 32'h100, 32'h30, 6'b0, 0, 1, 0, 1, 1);
    step();
    idle_req();
    n_chk++; if (bif.bjp_i_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_3: got %b want 0", bif.bjp_i_ready); end
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h14) begin n_fail++; $display("FAIL b2b_head_a: got %h want 14", bif.bjp_o_wbck_dat); end
    bif.bjp_o_ready = 1;
    step();
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h24) begin n_fail++; $display("FAIL b2b_head_b: got %h want 24", bif.bjp_o_wbck_dat); end
    n_chk++; if (bif.bjp_o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_b: got %b want 1", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop: got %b want 1", bif.bjp_i_ready); end
    step();
    bif.bjp_o_ready = 0;
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", bif.bjp_o_valid); end
  endtask

  task automatic test_flush();
    bif.bjp_o_ready = 0;
    set_req(32'h0, 32'h0, 32'h8, 32'h40, 6'b0, 0, 1, 0, 1, 1);
    step();
    set_req(32'h0, 32'h0, 32'h8, 32'h50, 6'b0, 0, 1, 0, 1, 1);
    step();
    n_chk++; if (bif.bjp_i_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", bif.bjp_i_ready); end
    set_req(32'h0, 32'h0, 32'h8, 32'h60, 6'b0, 0, 1, 0, 1, 1);
    bif.bjp_i_flush = 1;
    step();
    bif.bjp_i_flush = 0;
    idle_req();
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_i_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready: got %b want 1", bif.bjp_i_ready); end
    // flush with room: the offered request must be dropped
    set_req(32'h0, 32'h0, 32'h8, 32'h70, 6'b0, 0, 1, 0, 1, 1);
    step();
    set_req(32'h0, 32'h0, 32'h8, 32'h80, 6'b0, 0, 1, 0, 1, 1);
    bif.bjp_i_flush = 1;
    step();
    bif.bjp_i_flush = 0;
    idle_req();
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_valid: got %b want 0", bif.bjp_o_valid); end
    step();
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_later: got %b want 0", bif.bjp_o_valid); end
    set_req(32'h0, 32'h0, 32'h8, 32'h90, 6'b0, 0, 1, 0, 1, 1);
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_wbck_dat !== 32'h94) begin n_fail++; $display("FAIL flush_resume: got %h want 94", bif.bjp_o_wbck_dat); end
    bif.bjp_o_ready = 1;
    step();
    bif.bjp_o_ready = 0;
  endtask

  task automatic test_nonbjp_and_gating();
    idle_req();
    bif.bjp_i_valid = 1; bif.bjp_i_mret = 1; bif.bjp_i_bprdt = 1;
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_cmt_rslv !== 1'b0) begin n_fail++; $display("FAIL mret_rslv: got %b want 0", bif.bjp_o_cmt_rslv); end
    n_chk++; if (bif.bjp_o_cmt_mispred !== 1'b0) begin n_fail++; $display("FAIL mret_mispred: got %b want 0", bif.bjp_o_cmt_mispred); end
    n_chk++; if (bif.bjp_o_wbck_en !== 1'b0) begin n_fail++; $display("FAIL mret_wbck_en: got %b want 0", bif.bjp_o_wbck_en); end
    n_chk++; if ({bif.bjp_o_cmt_mret, bif.bjp_o_cmt_bjp} !== 2'b10) begin n_fail++; $display("FAIL mret_flags: got %b want 10", {bif.bjp_o_cmt_mret, bif.bjp_o_cmt_bjp}); end
    bif.bjp_o_ready = 1;
    // JAL predicted not-taken: mispredicted and writing rd
    set_req(32'h0, 32'h0, 32'h30, 32'h500, 6'b0, 0, 1, 0, 1, 0);
    step();
    idle_req();
    n_chk++; if ({bif.bjp_o_cmt_mispred, bif.bjp_o_wbck_en} !== 2'b11) begin n_fail++; $display("FAIL jal_mispred_wb: got %b want 11", {bif.bjp_o_cmt_mispred, bif.bjp_o_wbck_en}); end
    step();
    bif.bjp_o_ready = 0;
    n_chk++; if ({bif.bjp_o_valid, bif.bjp_o_cmt_mispred, bif.bjp_o_wbck_en} !== 3'b000) begin
      n_fail++; $display("FAIL gating_idle: got %b want 000", {bif.bjp_o_valid, bif.bjp_o_cmt_mispred, bif.bjp_o_wbck_en});
    end
  endtask

  task automatic test_async_reset();
    set_req(32'h0, 32'h0, 32'h8, 32'h600, 6'b0, 0, 1, 0, 1, 1);
    step();
    idle_req();
    n_chk++; if (bif.bjp_o_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b want 1", bif.bjp_o_valid); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", bif.bjp_o_valid); end
    n_chk++; if (bif.bjp_i_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", bif.bjp_i_ready); end
    @(posedge clk);
    #1 rst_n = 1;
    step();
    n_chk++; if (bif.bjp_o_valid !== 1'b0) begin n_fail++; $display("FAIL areset_post: got %b want 0", bif.bjp_o_valid); end
  endtask

`ifdef E203_BJP_STAT_EN
  task automatic test_stat();
    bif.bjp_o_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_req(32'h3, 32'h3, 32'h10, 32'h700 + 32'(i * 8), 6'b000001, 1, 0, 0, 1, (i < 3));
      step();
    end
    idle_req();
    step();
    n_chk++; if (stat_taken !== 32'd5) begin n_fail++; $display("FAIL stat_taken: got %0d want 5", stat_taken); end
    n_chk++; if (stat_mispred !== 32'd2) begin n_fail++; $display("FAIL stat_mispred: got %0d want 2", stat_mispred); end
    force dut.stat_taken_q = 32'hFFFF_FFFF;
    #1 release dut.stat_taken_q;
    set_req(32'h3, 32'h3, 32'h10, 32'h800, 6'b000001, 1, 0, 0, 1, 0);
    step();
    idle_req();
    step();
    bif.bjp_o_ready = 0;
    n_chk++; if (stat_taken !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stat_saturate: got %h want ffffffff", stat_taken); end
    n_chk++; if (stat_mispred !== 32'd3) begin n_fail++; $display("FAIL stat_mispred_after: got %0d want 3", stat_mispred); end
  endtask
`endif

  initial begin
    test_reset();
    test_beq();
    test_jalr();
    test_cmp_signed();
    test_cmp_table();
    test_back_to_back();
    test_flush();
    test_nonbjp_and_gating();
    test_async_reset();
`ifdef E203_BJP_STAT_EN
    test_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
